// File: rtl/loopback_mc_fifo_pkg.sv
// Shared types and sizing helpers for the multi-channel loopback FIFO.
package loopback_mc_fifo_pkg;

    // Widest configuration supported: 16 channels.
    localparam int MAX_CHANNELS = 16;
    localparam int CHAN_IDX_W   = 4;
    localparam int MAX_CNT_W    = 16;

    // Channel index wide enough for any supported channel count.
    typedef logic [CHAN_IDX_W-1:0] chan_idx_t;

    // Occupancy value wide enough for any practical per-channel depth.
    typedef logic [MAX_CNT_W-1:0] count_t;

    // Read/write pointer width for a power-of-two depth (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Channel-index port width, at least one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/loopback_chan_fifo.sv
// Single-channel FIFO: storage array, wrapping pointers, occupancy and full/empty.
// The head entry is always visible on rdata; pops and pushes beyond capacity are dropped.
module loopback_chan_fifo
    import loopback_mc_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 512,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [FIFO_WIDTH-1:0]         wdata,
    output logic [FIFO_WIDTH-1:0]         rdata,
    output logic [ptr_w(FIFO_DEPTH):0]    count,
    output logic                          empty,
    output logic                          full
);

    localparam int PTR_W = ptr_w(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; data array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/loopback_mc_fifo.sv
// Multi-channel FIFO with round-robin dequeue arbitration.
// Optional macro LOOPBACK_MC_FIFO_OUT_REG_EN adds a registered output stage
// (first word one cycle later, full throughput kept). Without it the granted
// channel head drives the outputs combinationally.
module loopback_mc_fifo
    import loopback_mc_fifo_pkg::*;
#(
    parameter int NUM_CHANNELS       = 4,
    parameter int FIFO_WIDTH         = 512,
    parameter int FIFO_DEPTH         = 8,
    parameter int ALMOST_FULL_THRESH = 6
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic [NUM_CHANNELS*FIFO_WIDTH-1:0]              enq_data,
    input  logic [NUM_CHANNELS-1:0]                         enq_valid,
    output logic [NUM_CHANNELS-1:0]                         enq_ready,
    output logic [NUM_CHANNELS-1:0]                         almost_full,
    output logic [FIFO_WIDTH-1:0]                           deq_data,
    output logic                                            deq_valid,
    input  logic                                            deq_ready,
    output logic [chan_w(NUM_CHANNELS)-1:0]                 deq_chan,
    output logic [NUM_CHANNELS*(ptr_w(FIFO_DEPTH)+1)-1:0]   count
);

    localparam int          CHAN_W = chan_w(NUM_CHANNELS);
    localparam int          CNT_W  = ptr_w(FIFO_DEPTH) + 1;
    localparam int unsigned NCH_U  = NUM_CHANNELS;

    logic [FIFO_WIDTH-1:0]   head     [NUM_CHANNELS];
    logic [CNT_W-1:0]        fifo_cnt [NUM_CHANNELS];
    logic [CNT_W-1:0]        occ      [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] fifo_full;
    logic [NUM_CHANNELS-1:0] fifo_empty;
    logic [NUM_CHANNELS-1:0] push;
    logic [NUM_CHANNELS-1:0] pop;
    logic [MAX_CHANNELS-1:0] nonempty;
    chan_idx_t               rr_ptr;
    chan_idx_t               grant_chan;
    logic                    grant_vld;

    // Channel reached by stepping 'off' positions past 'base', modulo the channel count.
    function automatic chan_idx_t rr_idx(input chan_idx_t base, input int unsigned off);
        int unsigned s;
        s = (32'(base) + off) % NCH_U;
        return chan_idx_t'(s);
    endfunction

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        loopback_chan_fifo #(
            .FIFO_WIDTH (FIFO_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push[c]),
            .pop     (pop[c]),
            .wdata   (enq_data[c*FIFO_WIDTH +: FIFO_WIDTH]),
            .rdata   (head[c]),
            .count   (fifo_cnt[c]),
            .empty   (fifo_empty[c]),
            .full    (fifo_full[c])
        );

        // Occupancy counts every entry the block holds for the channel, including
        // one parked in the output stage, so flow control is identical in both builds.
        assign enq_ready[c]               = (occ[c] < CNT_W'(FIFO_DEPTH));
        assign almost_full[c]             = (occ[c] >= CNT_W'(ALMOST_FULL_THRESH));
        assign push[c]                    = enq_valid[c] && enq_ready[c] && !fifo_full[c];
        assign count[c*CNT_W +: CNT_W]    = occ[c];
    end

    // Non-empty flags padded to the widest channel count for index-width-clean lookup.
    always_comb begin
        nonempty = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            nonempty[c] = !fifo_empty[c];
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        grant_vld  = 1'b0;
        grant_chan = '0;
        for (int unsigned i = 1; i <= NCH_U; i++) begin
            if (!grant_vld && nonempty[rr_idx(rr_ptr, i)]) begin
                grant_vld  = 1'b1;
                grant_chan = rr_idx(rr_ptr, i);
            end
        end
    end

`ifdef LOOPBACK_MC_FIFO_OUT_REG_EN

    logic                  vld_p1;
    chan_idx_t             chan_p1;
    logic [FIFO_WIDTH-1:0] data_p1;
    logic                  load;

    // Refill the output stage whenever it is empty or being drained this cycle.
    assign load = grant_vld && (!vld_p1 || deq_ready);

    // Pop the granted head into the output stage; account for the parked entry.
    always_comb begin
        pop = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            pop[c] = load && (grant_chan == chan_idx_t'(c));
            occ[c] = fifo_cnt[c] + CNT_W'(vld_p1 && (chan_p1 == chan_idx_t'(c)));
        end
    end

    // Stage p1 control: output valid, channel tag and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            chan_p1 <= '0;
            rr_ptr  <= chan_idx_t'(NUM_CHANNELS - 1);
        end else if (load) begin
            vld_p1  <= 1'b1;
            chan_p1 <= grant_chan;
            rr_ptr  <= grant_chan;
        end else if (deq_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    // Stage p1 data; not reset, meaningless while vld_p1 is low.
    always_ff @(posedge clk) begin
        if (load) begin
            data_p1 <= head[grant_chan[CHAN_W-1:0]];
        end
    end

    assign deq_valid = vld_p1;
    assign deq_chan  = chan_p1[CHAN_W-1:0];
    assign deq_data  = data_p1;

`else

    logic      lock_vld_p1;
    chan_idx_t lock_chan_p1;
    logic      sel_vld;
    chan_idx_t sel_chan;
    logic      xfer;

    // A stalled grant stays locked so a newly filled channel cannot take over.
    always_comb begin
        sel_vld  = lock_vld_p1 || grant_vld;
        sel_chan = lock_vld_p1 ? lock_chan_p1 : grant_chan;
    end

    assign xfer = sel_vld && deq_ready;

    // Handshake pops the selected head; occupancy is the raw channel count.
    always_comb begin
        pop = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            pop[c] = xfer && (sel_chan == chan_idx_t'(c));
            occ[c] = fifo_cnt[c];
        end
    end

    // Grant lock and round-robin pointer, which moves only on a transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_vld_p1  <= 1'b0;
            lock_chan_p1 <= '0;
            rr_ptr       <= chan_idx_t'(NUM_CHANNELS - 1);
        end else begin
            lock_vld_p1  <= sel_vld && !deq_ready;
            lock_chan_p1 <= sel_chan;
            if (xfer) begin
                rr_ptr <= sel_chan;
            end
        end
    end

    assign deq_valid = sel_vld;
    assign deq_chan  = sel_chan[CHAN_W-1:0];
    assign deq_data  = head[sel_chan[CHAN_W-1:0]];

`endif

endmodule

// File: tb/tb_loopback_mc_fifo.sv
// Directed self-checking bench for loopback_mc_fifo (4 channels, depth 8, 32-bit data).
module tb_loopback_mc_fifo;

    localparam int NCH = 4;
    localparam int W   = 32;
    localparam int D   = 8;
    localparam int CW  = 4;
`ifdef LOOPBACK_MC_FIFO_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [NCH*W-1:0] enq_data;
    logic [NCH-1:0]  enq_valid;
    logic [NCH-1:0]  enq_ready;
    logic [NCH-1:0]  almost_full;
    logic [W-1:0]    deq_data;
    logic            deq_valid;
    logic            deq_ready;
    logic [1:0]      deq_chan;
    logic [NCH*CW-1:0] count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    loopback_mc_fifo #(
        .NUM_CHANNELS       (NCH),
        .FIFO_WIDTH         (W),
        .FIFO_DEPTH         (D),
        .ALMOST_FULL_THRESH (6)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enq_data    (enq_data),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .almost_full (almost_full),
        .deq_data    (deq_data),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_chan    (deq_chan),
        .count       (count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] cnt_of(input int c);
        return count[c*CW +: CW];
    endfunction

    task automatic idle();
        enq_valid = '0;
        enq_data  = '0;
        deq_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        #2;
        n_vec++; if (enq_ready !== 4'hF) begin n_err++; $display("FAIL reset_enq_ready: got %h want %h", enq_ready, 4'hF); end
        n_vec++; if (almost_full !== 4'h0) begin n_err++; $display("FAIL reset_almost_full: got %h want %h", almost_full, 4'h0); end
        n_vec++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL reset_deq_valid: got %b want 0", deq_valid); end
        n_vec++; if (deq_chan !== 2'd0) begin n_err++; $display("FAIL reset_deq_chan: got %0d want 0", deq_chan); end
        n_vec++; if (count !== '0) begin n_err++; $display("FAIL reset_count: got %h want 0", count); end
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_fill_ch0();
        logic exp_first;
        exp_first = (LAT == 1);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            enq_valid[0]    = 1'b1;
            enq_data[0 +: W] = W'(32'h100 + i);
            step();
            if (i == 0) begin
                n_vec++; if (deq_valid !== exp_first) begin n_err++; $display("FAIL first_word_latency_n1: got %b want %b", deq_valid, exp_first); end
            end
            if (i == 1) begin
                n_vec++; if (deq_valid !== 1'b1) begin n_err++; $display("FAIL first_word_latency_n2: got %b want 1", deq_valid); end
            end
        end
        idle();
        n_vec++; if (cnt_of(0) !== 4'd8) begin n_err++; $display("FAIL fill_count0: got %0d want 8", cnt_of(0)); end
        n_vec++; if (enq_ready[0] !== 1'b0) begin n_err++; $display("FAIL fill_enq_ready0: got %b want 0", enq_ready[0]); end
        n_vec++; if (almost_full[0] !== 1'b1) begin n_err++; $display("FAIL fill_almost_full0: got %b want 1", almost_full[0]); end
        n_vec++; if (deq_data !== 32'h100) begin n_err++; $display("FAIL fill_head: got %h want %h", deq_data, 32'h100); end
        enq_valid[0]     = 1'b1;
        enq_data[0 +: W] = 32'hDEAD;
        step();
        idle();
        n_vec++; if (cnt_of(0) !== 4'd8) begin n_err++; $display("FAIL ninth_push_ignored: got %0d want 8", cnt_of(0)); end
        for (int k = 0; k < 8; k++) begin
            deq_ready = 1'b1;
            n_vec++; if (deq_valid !== 1'b1 || deq_chan !== 2'd0 || deq_data !== W'(32'h100 + k))
                begin n_err++; $display("FAIL drain0_%0d: got v=%b ch=%0d d=%h want v=1 ch=0 d=%h", k, deq_valid, deq_chan, deq_data, 32'h100 + k); end
            step();
        end
        deq_ready = 1'b0;
        n_vec++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL drain0_empty: got %b want 0", deq_valid); end
        n_vec++; if (enq_ready !== 4'hF) begin n_err++; $display("FAIL drain0_enq_ready: got %h want F", enq_ready); end
    endtask

    task automatic test_round_robin();
        int exp_c;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NCH; c++) begin
                enq_valid[c]     = 1'b1;
                enq_data[c*W +: W] = W'(32'h200 + c*16 + k);
            end
            step();
        end
        idle();
        step();
        for (int t = 0; t < 8; t++) begin
            exp_c = t % 4;
            deq_ready = 1'b1;
            n_vec++; if (deq_valid !== 1'b1 || deq_chan !== 2'(exp_c) || deq_data !== W'(32'h200 + exp_c*16 + t/4))
                begin n_err++; $display("FAIL rr_%0d: got v=%b ch=%0d d=%h want ch=%0d d=%h", t, deq_valid, deq_chan, deq_data, exp_c, 32'h200 + exp_c*16 + t/4); end
            step();
        end
        deq_ready = 1'b0;
        n_vec++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL rr_empty: got %b want 0", deq_valid); end
    endtask

    task automatic test_almost_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            enq_valid = (i < 5) ? 4'b0110 : 4'b0100;
            enq_data[1*W +: W] = W'(32'h300 + i);
            enq_data[2*W +: W] = W'(32'h400 + i);
            step();
        end
        idle();
        step();
        n_vec++; if (cnt_of(2) !== 4'd8 || enq_ready[2] !== 1'b0) begin n_err++; $display("FAIL af_ch2_full: got cnt=%0d rdy=%b want cnt=8 rdy=0", cnt_of(2), enq_ready[2]); end
        n_vec++; if (cnt_of(1) !== 4'd5 || almost_full[1] !== 1'b0) begin n_err++; $display("FAIL af_ch1_at5: got cnt=%0d af=%b want cnt=5 af=0", cnt_of(1), almost_full[1]); end
        n_vec++; if (deq_chan !== 2'd1 || deq_data !== 32'h300) begin n_err++; $display("FAIL af_grant: got ch=%0d d=%h want ch=1 d=%h", deq_chan, deq_data, 32'h300); end
        enq_valid[1]       = 1'b1;
        enq_data[1*W +: W] = 32'h305;
        deq_ready          = 1'b1;
        step();
        idle();
        n_vec++; if (cnt_of(1) !== 4'd5 || almost_full[1] !== 1'b0) begin n_err++; $display("FAIL af_push_pop: got cnt=%0d af=%b want cnt=5 af=0", cnt_of(1), almost_full[1]); end
        n_vec++; if (cnt_of(2) !== 4'd8) begin n_err++; $display("FAIL af_ch2_kept: got %0d want 8", cnt_of(2)); end
        enq_valid[1]       = 1'b1;
        enq_data[1*W +: W] = 32'h306;
        step();
        idle();
        n_vec++; if (cnt_of(1) !== 4'd6 || almost_full[1] !== 1'b1 || enq_ready[1] !== 1'b1)
            begin n_err++; $display("FAIL af_reach6: got cnt=%0d af=%b rdy=%b want cnt=6 af=1 rdy=1", cnt_of(1), almost_full[1], enq_ready[1]); end
    endtask

    task automatic test_stall();
        do_reset();
        enq_valid[1]       = 1'b1;
        enq_data[1*W +: W] = 32'h41;
        step();
        idle();
        for (int j = 1; j < LAT; j++) step();
        for (int s = 0; s < 5; s++) begin
            enq_valid[0]       = 1'b1;
            enq_data[0*W +: W] = W'(32'h500 + s);
            n_vec++; if (deq_valid !== 1'b1 || deq_chan !== 2'd1 || deq_data !== 32'h41)
                begin n_err++; $display("FAIL stall_%0d: got v=%b ch=%0d d=%h want v=1 ch=1 d=41", s, deq_valid, deq_chan, deq_data); end
            step();
        end
        idle();
        n_vec++; if (deq_chan !== 2'd1 || deq_data !== 32'h41) begin n_err++; $display("FAIL stall_hold: got ch=%0d d=%h want ch=1 d=41", deq_chan, deq_data); end
        n_vec++; if (cnt_of(0) !== 4'd5) begin n_err++; $display("FAIL stall_count0: got %0d want 5", cnt_of(0)); end
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        n_vec++; if (deq_valid !== 1'b1 || deq_chan !== 2'd0 || deq_data !== 32'h500)
            begin n_err++; $display("FAIL stall_release: got v=%b ch=%0d d=%h want v=1 ch=0 d=500", deq_valid, deq_chan, deq_data); end
        n_vec++; if (cnt_of(1) !== 4'd0) begin n_err++; $display("FAIL stall_count1: got %0d want 0", cnt_of(1)); end
    endtask

    task automatic test_wrap_and_reset();
        int exp_v;
        exp_v = 0;
        do_reset();
        deq_ready = 1'b1;
        for (int cyc = 0; cyc < 20 + LAT + 2; cyc++) begin
            enq_valid = '0;
            if (cyc < 20) begin
                enq_valid[3]       = 1'b1;
                enq_data[3*W +: W] = W'(cyc);
            end
            if (deq_valid === 1'b1) begin
                n_vec++; if (deq_chan !== 2'd3 || deq_data !== W'(exp_v))
                    begin n_err++; $display("FAIL wrap_%0d: got ch=%0d d=%h want ch=3 d=%h", exp_v, deq_chan, deq_data, exp_v); end
                exp_v++;
            end
            step();
        end
        idle();
        n_vec++; if (exp_v !== 20) begin n_err++; $display("FAIL wrap_total: got %0d want 20", exp_v); end
        for (int i = 0; i < 5; i++) begin
            enq_valid            = 4'b1001;
            enq_data[0*W +: W]   = W'(32'h700 + i);
            enq_data[3*W +: W]   = W'(32'h600 + i);
            step();
        end
        idle();
        step();
        n_vec++; if (deq_valid !== 1'b1 || cnt_of(3) !== 4'd5) begin n_err++; $display("FAIL prereset_state: got v=%b cnt3=%0d want v=1 cnt3=5", deq_valid, cnt_of(3)); end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++; if (count !== '0) begin n_err++; $display("FAIL midreset_count: got %h want 0", count); end
        n_vec++; if (deq_valid !== 1'b0 || deq_chan !== 2'd0) begin n_err++; $display("FAIL midreset_deq: got v=%b ch=%0d want v=0 ch=0", deq_valid, deq_chan); end
        n_vec++; if (enq_ready !== 4'hF || almost_full !== 4'h0) begin n_err++; $display("FAIL midreset_flags: got rdy=%h af=%h want rdy=F af=0", enq_ready, almost_full); end
        step();
        reset_n = 1'b1;
        step();
        step();
        n_vec++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL postreset_empty: got %b want 0", deq_valid); end
    endtask

    initial begin
        test_reset();
        test_fill_ch0();
        test_round_robin();
        test_almost_full();
        test_stall();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/loopback_mc_fifo.md
LOOPBACK_MC_FIFO -- requirements
Module: loopback_mc_fifo

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of independent input channels (2..16).
REQ-002 SHALL have parameter FIFO_WIDTH, default 512, data bits per entry.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, entries per channel (power of two, >=2).
REQ-004 SHALL have parameter ALMOST_FULL_THRESH, default 6, occupancy at or above which almost_full asserts.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port enq_data  input  NUM_CHANNELS*FIFO_WIDTH  per-channel write data, channel c at bits [c*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 SHALL have port enq_valid  input  NUM_CHANNELS  per-channel write request.
REQ-009 SHALL have port enq_ready  output  NUM_CHANNELS  per-channel not-full.
REQ-010 SHALL have port almost_full  output  NUM_CHANNELS  per-channel occupancy >= ALMOST_FULL_THRESH.
REQ-011 SHALL have port deq_data  output  FIFO_WIDTH  head entry of granted channel.
REQ-012 SHALL have port deq_valid  output  1  a granted entry is presented.
REQ-013 SHALL have port deq_ready  input  1  consumer accepts deq_data this cycle.
REQ-014 SHALL have port deq_chan  output  max(1,$clog2(NUM_CHANNELS))  channel index of deq_data.
REQ-015 SHALL have port count  output  NUM_CHANNELS*($clog2(FIFO_DEPTH)+1)  per-channel occupancy, 0..FIFO_DEPTH.

Function
REQ-016 SHALL accept an enqueue on channel c when enq_valid[c] && enq_ready[c]; enq_valid while not ready SHALL be ignored, no state change.
REQ-017 SHALL assert enq_ready[c] iff count[c] < FIFO_DEPTH (all FIFO_DEPTH entries usable).
REQ-018 SHALL transfer a dequeue when deq_valid && deq_ready, popping the head of channel deq_chan.
REQ-019 SHALL keep count[c] unchanged on simultaneous enqueue and dequeue of channel c, including at count FIFO_DEPTH-to-be-freed (enq_ready low at full blocks enqueue regardless of dequeue).
REQ-020 SHALL wrap read/write pointers modulo FIFO_DEPTH without data loss or reordering within a channel.
REQ-021 SHALL select among non-empty channels round-robin, searching from (last granted + 1) mod NUM_CHANNELS; pointer advances only on a dequeue handshake.
REQ-022 SHALL hold deq_data, deq_chan and deq_valid stable while deq_valid && !deq_ready (grant locked; newly non-empty channels cannot steal).
REQ-023 SHALL deassert deq_valid only when all channels are empty (without output register).
REQ-024 SHALL present an entry enqueued in cycle N into an empty block at deq_valid in cycle N+1 (no same-cycle bypass).
REQ-025 SHALL compute almost_full[c] as count[c] >= ALMOST_FULL_THRESH, registered-count based, no extra latency.

Reset
REQ-026 SHALL, on reset_n low, asynchronously clear all pointers and counts, set enq_ready all ones, almost_full zero, deq_valid 0, deq_chan 0, round-robin pointer so channel 0 wins first.
REQ-027 SHALL discard in-flight/stalled entries on reset mid-operation; storage array SHALL not be reset and deq_data is don't-care while deq_valid is 0.

Configuration
REQ-028 SHALL, with LOOPBACK_MC_FIFO_OUT_REG_EN defined, add a registered output stage: deq_data/deq_chan/deq_valid from flops, first-word latency N+2, full throughput (one transfer per cycle with deq_ready held high) preserved.
REQ-029 SHALL, without LOOPBACK_MC_FIFO_OUT_REG_EN, drive outputs combinationally from the granted channel head with latency per REQ-024.

Structure
REQ-030 SHALL place channel-index and count typedefs and the pointer-width function in package loopback_mc_fifo_pkg.
REQ-031 SHALL instantiate one sub-module loopback_chan_fifo per channel (single-channel storage, pointers, count, full/empty); arbitration and output stage in the top.

Verification
REQ-032 SHALL cover: reset, push 8 entries to channel 0 with deq_ready=0 -> enq_ready[0]=0 after 8th, count[0]=8, 9th push ignored.
REQ-033 SHALL cover: channels 0..3 each hold 2 entries, deq_ready=1 -> deq_chan sequence 0,1,2,3,0,1,2,3, per-channel data order preserved.
REQ-034 SHALL cover: channel 2 full, simultaneous push and pop on channel 1 at count 5 -> count[1] stays 5, almost_full[1]=0; push to reach 6 -> almost_full[1]=1.
REQ-035 SHALL cover: deq_valid on channel 1 stalled 5 cycles while channel 0 fills -> deq_chan and deq_data unchanged until handshake.
REQ-036 SHALL cover: 20 push/pop pairs on channel 3 (pointer wraps twice) -> values 0..19 in order; reset_n pulse mid-stream -> all counts 0, deq_valid 0 within the same cycle.
REQ-037 SHALL run every scenario with and without LOOPBACK_MC_FIFO_OUT_REG_EN, checking N+1 vs N+2 first-word latency.
